// File: rtl/vga_scanout.sv
// vga_scanout: parametrised VGA timing generator with integer-scaled, centred
// frame-buffer scanout, writable palette and programmable border colour.
// The address and colour pipeline is built from counters only, with no
// multipliers or dividers. Pins trail the timing counters by RD_LATENCY+1
// pixel ticks, and sync and colour stay aligned.
module vga_scanout #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SRC_W      = 160,
  parameter int SRC_H      = 144,
  parameter int SCALE      = 3,
  parameter int PIX_BITS   = 2,
  parameter int RD_LATENCY = 2,
  parameter bit SYNC_POL   = 1'b0,
  localparam int ADDR_W    = $clog2(SRC_W * SRC_H)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                pix_en,
  input  logic [11:0]         border_rgb,
  input  logic                pal_wren,
  input  logic [PIX_BITS-1:0] pal_idx,
  input  logic [11:0]         pal_data,
  output logic [ADDR_W-1:0]   fb_rd_addr,
  input  logic [PIX_BITS-1:0] fb_rd_data,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic [3:0]          VGA_R,
  output logic [3:0]          VGA_G,
  output logic [3:0]          VGA_B,
  output logic [9:0]          DrawX,
  output logic [9:0]          DrawY,
  output logic                frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int WIN_W   = SRC_W * SCALE;
  localparam int WIN_H   = SRC_H * SCALE;
  localparam int X0      = (H_VISIBLE - WIN_W) / 2;
  localparam int Y0      = (V_VISIBLE - WIN_H) / 2;
  localparam int PAL_N   = 2 ** PIX_BITS;
  localparam int SUB_W   = $clog2(SCALE + 1);
  localparam int SX_W    = $clog2(SRC_W + 1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] X_LO   = 10'(X0);
  localparam logic [9:0] X_HI   = 10'(X0 + WIN_W);
  localparam logic [9:0] Y_LO   = 10'(Y0);
  localparam logic [9:0] Y_HI   = 10'(Y0 + WIN_H);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

  // Reset contents of the palette: an evenly spaced grey ramp from white to black.
  function automatic logic [11:0] greyRamp(input int idx);
    int g;
    g = 15 - (15 * idx) / (PAL_N - 1);
    return {3{4'(g)}};
  endfunction

  function automatic logic inWin(input logic [9:0] h, input logic [9:0] v);
    return (h >= X_LO) && (h < X_HI) && (v >= Y_LO) && (v < Y_HI);
  endfunction

  logic [9:0]        r_hcnt, r_vcnt;
  logic [SUB_W-1:0]  r_xsub, r_ysub;
  logic [SX_W-1:0]   r_sx;
  logic [ADDR_W-1:0] r_row_base, r_addr;
  logic [3:0]        r_dly [RD_LATENCY];
  logic [11:0]       r_pal [PAL_N];
  logic              r_hs, r_vs;
  logic [11:0]       r_rgb;

  logic [9:0]        w_hcnt_n, w_vcnt_n;
  logic [SUB_W-1:0]  w_xsub_n, w_ysub_n;
  logic [SX_W-1:0]   w_sx_n;
  logic [ADDR_W-1:0] w_row_n;
  logic              w_h_wrap, w_in_x, w_in_y, w_win_n;
  logic              w_hs0, w_vs0, w_act0, w_win0;
  logic [3:0]        w_tail;

  assign w_in_x = (r_hcnt >= X_LO) && (r_hcnt < X_HI);
  assign w_in_y = (r_vcnt >= Y_LO) && (r_vcnt < Y_HI);
  assign w_hs0  = (r_hcnt >= HS_LO) && (r_hcnt < HS_HI);
  assign w_vs0  = (r_vcnt >= VS_LO) && (r_vcnt < VS_HI);
  assign w_act0 = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
  assign w_win0 = w_act0 && inWin(r_hcnt, r_vcnt);
  assign w_tail = r_dly[RD_LATENCY-1];

  // Next position of the raster counters and of the scaled source coordinates.
  always_comb begin
    w_h_wrap = (r_hcnt == H_LAST);
    w_hcnt_n = w_h_wrap ? 10'd0 : r_hcnt + 10'd1;
    w_vcnt_n = r_vcnt;
    w_xsub_n = r_xsub;
    w_sx_n   = r_sx;
    w_ysub_n = r_ysub;
    w_row_n  = r_row_base;
    if (w_h_wrap) begin
      w_vcnt_n = (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
      w_xsub_n = '0;
      w_sx_n   = '0;
      if (w_vcnt_n == 10'd0) begin
        w_ysub_n = '0;
        w_row_n  = '0;
      end else if (w_in_y) begin
        if (r_ysub == SUB_LAST) begin
          w_ysub_n = '0;
          w_row_n  = r_row_base + ADDR_W'(SRC_W);
        end else begin
          w_ysub_n = r_ysub + 1'b1;
        end
      end
    end else if (w_in_x) begin
      if (r_xsub == SUB_LAST) begin
        w_xsub_n = '0;
        w_sx_n   = r_sx + 1'b1;
      end else begin
        w_xsub_n = r_xsub + 1'b1;
      end
    end
    w_win_n = inWin(w_hcnt_n, w_vcnt_n);
  end

  // Stage 0: advance counters and register the address of the new position.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_xsub     <= '0;
      r_sx       <= '0;
      r_ysub     <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
    end else if (pix_en) begin
      r_hcnt     <= w_hcnt_n;
      r_vcnt     <= w_vcnt_n;
      r_xsub     <= w_xsub_n;
      r_sx       <= w_sx_n;
      r_ysub     <= w_ysub_n;
      r_row_base <= w_row_n;
      if (w_win_n) r_addr <= w_row_n + ADDR_W'(w_sx_n);
    end
  end

  // Delay sync, active and window flags until the matching pixel data returns.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) r_dly[i] <= '0;
    end else if (pix_en) begin
      r_dly[0] <= {w_hs0, w_vs0, w_act0, w_win0};
      for (int i = 1; i < RD_LATENCY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  // Palette: grey ramp on reset, written on any clock regardless of pix_en.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < PAL_N; i++) r_pal[i] <= greyRamp(i);
    end else if (pal_wren) begin
      r_pal[pal_idx] <= pal_data;
    end
  end

  // Output stage: sync levels plus blank/border/palette colour select.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hs  <= ~SYNC_POL;
      r_vs  <= ~SYNC_POL;
      r_rgb <= '0;
    end else if (pix_en) begin
      r_hs <= w_tail[3] ? SYNC_POL : ~SYNC_POL;
      r_vs <= w_tail[2] ? SYNC_POL : ~SYNC_POL;
      if (!w_tail[1])     r_rgb <= '0;
      else if (w_tail[0]) r_rgb <= r_pal[fb_rd_data];
      else                r_rgb <= border_rgb;
    end
  end

  assign fb_rd_addr  = r_addr;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_R       = r_rgb[11:8];
  assign VGA_G       = r_rgb[7:4];
  assign VGA_B       = r_rgb[3:0];
  assign DrawX       = r_hcnt;
  assign DrawY       = r_vcnt;
  assign frame_start = Reset_n & pix_en & (r_hcnt == 10'd0) & (r_vcnt == 10'd0);

endmodule

// File: tb/tb_vga_scanout.sv
// Testbench for vga_scanout on a reduced raster so several frames fit in a short run.
// A behavioural model derives every expected output from the raster position
// (tick count since reset) using plain arithmetic on the timing rules.
module tb_vga_scanout;

  localparam int HV = 65, HF = 4, HSW = 8, HB = 4;
  localparam int VV = 41, VF = 2, VSW = 2, VB = 3;
  localparam int SW = 16, SH = 12, SC = 3, RD = 2;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int X0 = (HV - SW * SC) / 2;
  localparam int Y0 = (VV - SH * SC) / 2;
  localparam int AW = $clog2(SW * SH);

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          pix_en = 1'b0;
  logic [11:0]   border_rgb = 12'h000;
  logic          pal_wren = 1'b0;
  logic [1:0]    pal_idx = 2'd0;
  logic [11:0]   pal_data = 12'h000;
  logic [AW-1:0] fb_rd_addr;
  logic [1:0]    fb_rd_data;
  logic          VGA_HS, VGA_VS;
  logic [3:0]    VGA_R, VGA_G, VGA_B;
  logic [9:0]    DrawX, DrawY;
  logic          frame_start;

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .SRC_W(SW), .SRC_H(SH), .SCALE(SC), .PIX_BITS(2),
    .RD_LATENCY(RD), .SYNC_POL(1'b0)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en), .border_rgb(border_rgb),
    .pal_wren(pal_wren), .pal_idx(pal_idx), .pal_data(pal_data),
    .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start)
  );

  always #10 Clk = ~Clk;

  logic [1:0]  fbmem [SW*SH];
  logic [1:0]  memStage0 = 2'd0;
  logic [1:0]  memStage1 = 2'd0;
  logic [11:0] modelPal [4];

  // Frame-buffer memory with a two-tick read latency.
  always @(posedge Clk) begin
    if (pix_en) begin
      memStage0 <= (int'(fb_rd_addr) < SW * SH) ? fbmem[fb_rd_addr] : 2'd0;
      memStage1 <= memStage0;
    end
  end
  assign fb_rd_data = memStage1;

  int assertCount = 0;
  int failCount = 0;
  int pcount = 0;
  int freezeLeft = 0;
  int expHs = 1, expVs = 1, expRgb = 0, expAddr = 0;
  bit resetDone = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (tick %0d)", tag, observed, expected, pcount);
    end
  endtask

  function automatic bit inWinM(input int x, input int y);
    return (x >= X0) && (x < X0 + SW * SC) && (y >= Y0) && (y < Y0 + SH * SC);
  endfunction

  function automatic int addrM(input int x, input int y);
    return ((y - Y0) / SC) * SW + (x - X0) / SC;
  endfunction

  task automatic loadGreyRamp();
    modelPal[0] = 12'hFFF;
    modelPal[1] = 12'hAAA;
    modelPal[2] = 12'h555;
    modelPal[3] = 12'h000;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "DrawX"}, int'(DrawX), 0);
    checkOutput({tag, "DrawY"}, int'(DrawY), 0);
    checkOutput({tag, "HS"}, int'(VGA_HS), 1);
    checkOutput({tag, "VS"}, int'(VGA_VS), 1);
    checkOutput({tag, "RGB"}, int'({VGA_R, VGA_G, VGA_B}), 0);
    checkOutput({tag, "Addr"}, int'(fb_rd_addr), 0);
    checkOutput({tag, "FrameStart"}, int'(frame_start), 0);
  endtask

  // Holds reset for several clocks with pix_en toggling, then restarts the model.
  task automatic resetPhase();
    Reset_n = 1'b0;
    pal_wren = 1'b0;
    pix_en = 1'b1;
    #1;
    checkResetOutputs("rstNow");
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      checkResetOutputs("rstHold");
      pix_en = ~pix_en;
    end
    pcount = 0;
    expHs = 1;
    expVs = 1;
    expRgb = 0;
    expAddr = 0;
    loadGreyRamp();
    Reset_n = 1'b1;
  endtask

  // One clock of random stimulus followed by a full comparison against the model.
  task automatic applyStimulus();
    int j, jx, jy, x, y;
    if (freezeLeft > 0) begin
      pix_en = 1'b0;
      freezeLeft--;
    end else begin
      pix_en = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) freezeLeft = 10;
    end
    pal_wren = ($urandom_range(0, 59) == 0);
    pal_idx = 2'($urandom);
    pal_data = 12'($urandom);
    if ($urandom_range(0, 399) == 0) border_rgb = 12'($urandom);
    #1;
    checkOutput("frameStart", int'(frame_start), int'(pix_en && (pcount % FRAME) == 0));
    @(posedge Clk);
    @(negedge Clk);
    if (pix_en) begin
      j = pcount - RD;
      if (j < 0) begin
        expHs = 1;
        expVs = 1;
        expRgb = 0;
      end else begin
        jx = j % HT;
        jy = (j / HT) % VT;
        expHs = (jx >= HV + HF && jx < HV + HF + HSW) ? 0 : 1;
        expVs = (jy >= VV + VF && jy < VV + VF + VSW) ? 0 : 1;
        if (!(jx < HV && jy < VV)) expRgb = 0;
        else if (inWinM(jx, jy)) expRgb = int'(modelPal[fbmem[addrM(jx, jy)]]);
        else expRgb = int'(border_rgb);
      end
      pcount++;
      x = pcount % HT;
      y = (pcount / HT) % VT;
      if (inWinM(x, y)) expAddr = addrM(x, y);
    end
    if (pal_wren) modelPal[pal_idx] = pal_data;
    checkOutput("DrawX", int'(DrawX), pcount % HT);
    checkOutput("DrawY", int'(DrawY), (pcount / HT) % VT);
    checkOutput("fbAddr", int'(fb_rd_addr), expAddr);
    checkOutput("HS", int'(VGA_HS), expHs);
    checkOutput("VS", int'(VGA_VS), expVs);
    checkOutput("RGB", int'({VGA_R, VGA_G, VGA_B}), expRgb);
  endtask

  initial begin
    for (int i = 0; i < SW * SH; i++) fbmem[i] = 2'($urandom);
    loadGreyRamp();
    @(negedge Clk);
    resetPhase();
    for (int c = 0; c < 30000 && !resetDone; c++) begin
      applyStimulus();
      if (pcount >= 2 * FRAME + 20 * HT + 30) begin
        $display("[TB] mid-frame reset at DrawY %0d", DrawY);
        resetPhase();
        resetDone = 1;
      end
    end
    if (!resetDone) checkOutput("resetReached", 0, 1);
    for (int c = 0; c < 7000; c++) applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Parametrised VGA timing generator and scaled frame-buffer scanout.
- Replaces the fixed 640x480 controller plus ad-hoc colour mux at the top level.
- Generates sync and blank, and issues linear read addresses into the Game Boy frame buffer. The 160x144 source image is integer-scaled and centred in the visible area.
- Maps each pixel index through a writable palette. Draws a programmable border colour outside the image window.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BACK, 48, horizontal back porch, in pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BACK, 33, vertical back porch, in lines
- SRC_W, 160, source image width
- SRC_H, 144, source image height
- SCALE, 3, integer magnification; SRC_W*SCALE must not exceed H_VISIBLE, and SRC_H*SCALE must not exceed V_VISIBLE
- PIX_BITS, 2, bits per source pixel (palette index)
- RD_LATENCY, 2, frame-buffer read latency in pix_en ticks, ≥1
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- Clk, in, 1, system clock (50 MHz)
- Reset_n, in, 1, asynchronous active-low reset
- pix_en, in, 1, pixel-rate enable (25 MHz tick); all state advances only when high
- border_rgb, in, 12, {R,G,B} 4-bit colour used outside the window
- pal_wren, in, 1, palette write strobe (sampled every Clk, independent of pix_en)
- pal_idx, in, PIX_BITS, palette entry to write
- pal_data, in, 12, {R,G,B} value to write
- fb_rd_addr, out, clog2(SRC_W*SRC_H), frame-buffer read address
- fb_rd_data, in, PIX_BITS, frame-buffer pixel; valid RD_LATENCY ticks after its address
- VGA_HS, out, 1, horizontal sync
- VGA_VS, out, 1, vertical sync
- VGA_R, out, 4, red
- VGA_G, out, 4, green
- VGA_B, out, 4, blue
- DrawX, out, 10, current horizontal counter (stage 0)
- DrawY, out, 10, current vertical counter (stage 0)
- frame_start, out, 1, one-Clk pulse on the pix_en tick where hcnt=0 and vcnt=0

Behaviour:
Reset state:
- Reset_n low asynchronously clears hcnt, vcnt, the scale sub-counters, sx, row_base and every pipeline stage.
- Reset outputs: VGA_HS and VGA_VS at their inactive level (~SYNC_POL); RGB 0; fb_rd_addr 0; frame_start 0.
- Reset loads palette entry i with the grey ramp: nibble g = 15 - (15*i)/(2^PIX_BITS-1), replicated to R, G and B. With PIX_BITS=2 this gives FFF, AAA, 555, 000.

Timing counters (stage 0, advanced on pix_en):
- H_TOTAL = sum of the four H parameters; hcnt counts 0..H_TOTAL-1 and wraps to 0.
- vcnt increments when hcnt wraps, and wraps at V_TOTAL.
- HS is active for hcnt in [H_VISIBLE+H_FRONT, +H_SYNC); VS uses the same rule on vcnt.
- active = (hcnt < H_VISIBLE) and (vcnt < V_VISIBLE).

Window:
- X0 = (H_VISIBLE - SRC_W*SCALE)/2 and Y0 = (V_VISIBLE - SRC_H*SCALE)/2, truncating division. Defaults: X0=80, Y0=24.
- win = active and X0 ≤ hcnt < X0+SRC_W*SCALE and Y0 ≤ vcnt < Y0+SRC_H*SCALE.

Addressing (no multipliers or dividers):
- sx advances once every SCALE window pixels and resets at each line start.
- row_base advances by SRC_W once every SCALE window lines and resets at frame start.
- fb_rd_addr = row_base + sx, registered.
- Outside the window, fb_rd_addr holds its last value.

Pipeline:
- HS, VS, active and win are delayed RD_LATENCY ticks to align with fb_rd_data.
- One further registered stage does the palette lookup and colour select:
  - not active: RGB 0
  - active and not win: border_rgb
  - win: palette[fb_rd_data]
- Total latency from counters to pins is RD_LATENCY+1 pix_en ticks. Sync and colour stay mutually aligned.

Palette:
- A write updates the entry on that Clk edge.
- A lookup of the same entry on the same edge returns the old value; the new value applies from the next tick.

pix_en low:
- Every register except the palette freezes, and outputs hold.

Reset mid-frame:
- Scanout restarts at hcnt=vcnt=0 once reset is released.
- frame_start fires on the first pix_en tick after release.
- Palette contents revert to the grey ramp.

Test Plan:
- Reset check: hold Reset_n low with pix_en toggling → HS=VS=1, RGB=000, fb_rd_addr=0, palette reads FFF/AAA/555/000; release → frame_start on the first tick.
- Sync timing: run one line → HS low for exactly 96 ticks starting at hcnt=656, delayed by 3 ticks at the pins; VS low during vcnt 490–491; frame period 800x525 ticks.
- Address walk:
  - At (80,24) fb_rd_addr=0, and it stays 0 through (82,24); it is 1 at (83,24).
  - Row 27 starts at 160.
  - Last address 23039 at (557,455).
- Colour regions:
  - border_rgb=F00, fb constant index 3 → pins show F00 at x 0–79, 000 inside the window, F00 at x 560–639.
  - Blanking intervals show 000.
- Palette write: write idx 3 := 0F0 mid-line → window pixels change to 0F0 starting on the next tick.
- Freeze and reset: hold pix_en low 10 Clk mid-line → counters and pins unchanged; assert Reset_n at vcnt=200 → counters 0 immediately.
